uart_bdgen_frac: RTL

Fractional, runtime-reconfigurable baud generator for the UART. Produces a one-cycle rx oversampling pulse and a one-cycle tx bit pulse from a fixed-point divisor (integer + fraction), so standard baud rates are hit with low average error at any system clock. Adds safe config update (shadowed, applied on a tx bit boundary), rx phase resync on start-bit detect, global enable and config validation. Sits between the register interface and the uart tx/rx engines.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_frac_div.sv | 54 +++++
 rtl/uart_bdgen_frac.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART baud-generator types: config payload, widths and validation limits.
package uart_pkg;

    localparam int unsigned UART_DIV_W  = 16;
    localparam int unsigned UART_FRAC_W = 4;
    localparam int unsigned UART_OSR_W  = 5;

    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned MIN_OSR = 2;

    typedef struct packed {
        logic [UART_DIV_W-1:0]  div_int;
        logic [UART_FRAC_W-1:0] div_frac;
        logic [UART_OSR_W-1:0]  osr;
    } uart_cfg_bdfrac_t;

endpackage

// File: rtl/uart_frac_div.sv
// One fractional divider chain: period alternates int / int+1 so the mean is int + frac/2^FRAC_W.
module uart_frac_div #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [INT_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              pls_o
);

    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [INT_W-1:0]  limit;
    logic [FRAC_W:0]   acc_sum;

    // Pulse is a decode of the registered count, gated only by en.
    always_comb begin
        limit   = div_int_i - INT_W'(1) + INT_W'(ext_q);
        acc_sum = {1'b0, acc_q} + {1'b0, div_frac_i};
        pls_o   = en_i && (cnt_q == limit);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
        if (restart_i) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
        end else if (pls_o) begin
            cnt_d = '0;
            acc_d = acc_sum[FRAC_W-1:0];
            ext_d = acc_sum[FRAC_W];
        end else if (en_i) begin
            cnt_d = cnt_q + INT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            ext_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end

endmodule

// File: rtl/uart_bdgen_frac.sv
// Fractional UART baud generator: shadowed runtime config applied on a tx bit boundary,
// driving an rx oversampling chain and a tx bit chain.
module uart_bdgen_frac
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = UART_DIV_W,
    parameter int unsigned FRAC_W       = UART_FRAC_W,
    parameter int unsigned OSR_W        = UART_OSR_W,
    parameter int unsigned DEF_DIV_INT  = 27,
    parameter int unsigned DEF_DIV_FRAC = 2,
    parameter int unsigned DEF_OSR      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  cfg_div_int_i,
    input  logic [FRAC_W-1:0] cfg_div_frac_i,
    input  logic [OSR_W-1:0]  cfg_osr_i,
    input  logic              cfg_wr_i,
    output logic              cfg_busy_o,
    output logic              cfg_err_o,
    input  logic              rx_resync_i,
    output logic              pls_rx_o,
    output logic              pls_tx_o
);

    localparam int unsigned TX_W   = DIV_W + OSR_W;
    localparam int unsigned PROD_W = OSR_W + FRAC_W;

    localparam int unsigned DEF_TX_PROD = DEF_OSR * DEF_DIV_FRAC;
    localparam int unsigned DEF_TX_INT  = DEF_OSR * DEF_DIV_INT + (DEF_TX_PROD >> FRAC_W);
    localparam int unsigned DEF_TX_FRAC = DEF_TX_PROD % (2 ** FRAC_W);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam uart_cfg_bdfrac_t DEF_CFG = '{
        div_int:  UART_DIV_W'(DEF_DIV_INT),
        div_frac: UART_FRAC_W'(DEF_DIV_FRAC),
        osr:      UART_OSR_W'(DEF_OSR)
    };

    logic [0:0]        state_q, state_d;
    uart_cfg_bdfrac_t  shadow_q, shadow_d;
    logic [DIV_W-1:0]  rx_int_q, rx_int_d;
    logic [FRAC_W-1:0] rx_frac_q, rx_frac_d;
    logic [TX_W-1:0]   tx_int_q, tx_int_d;
    logic [FRAC_W-1:0] tx_frac_q, tx_frac_d;
    logic              err_q, err_d;

    logic              cfg_ok;
    logic              apply;
    logic [PROD_W-1:0] frac_prod;
    logic [TX_W-1:0]   tx_int_calc;

    // tx divisor = osr * (int + frac/2^FRAC_W), split back into integer and fraction.
    always_comb begin
        frac_prod   = PROD_W'(shadow_q.osr) * PROD_W'(shadow_q.div_frac);
        tx_int_calc = TX_W'(shadow_q.osr) * TX_W'(shadow_q.div_int)
                    + TX_W'(frac_prod >> FRAC_W);
    end

    // Config FSM: validation, shadow load and apply at a tx bit boundary (or while disabled).
    always_comb begin
        cfg_ok    = (cfg_div_int_i >= DIV_W'(MIN_DIV)) && (cfg_osr_i >= OSR_W'(MIN_OSR));
        apply     = (state_q == ST_PENDING) && (!en_i || pls_tx_o);
        state_d   = state_q;
        shadow_d  = shadow_q;
        rx_int_d  = rx_int_q;
        rx_frac_d = rx_frac_q;
        tx_int_d  = tx_int_q;
        tx_frac_d = tx_frac_q;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_PENDING: if (apply) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (apply) begin
            rx_int_d  = DIV_W'(shadow_q.div_int);
            rx_frac_d = FRAC_W'(shadow_q.div_frac);
            tx_int_d  = tx_int_calc;
            tx_frac_d = frac_prod[FRAC_W-1:0];
        end

        // A write on the apply cycle queues behind the config being applied.
        if (cfg_wr_i) begin
            if (cfg_ok) begin
                shadow_d.div_int  = UART_DIV_W'(cfg_div_int_i);
                shadow_d.div_frac = UART_FRAC_W'(cfg_div_frac_i);
                shadow_d.osr      = UART_OSR_W'(cfg_osr_i);
                state_d           = ST_PENDING;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shadow_q  <= DEF_CFG;
            rx_int_q  <= DIV_W'(DEF_DIV_INT);
            rx_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            tx_int_q  <= TX_W'(DEF_TX_INT);
            tx_frac_q <= FRAC_W'(DEF_TX_FRAC);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            rx_int_q  <= rx_int_d;
            rx_frac_q <= rx_frac_d;
            tx_int_q  <= tx_int_d;
            tx_frac_q <= tx_frac_d;
            err_q     <= err_d;
        end
    end

    assign cfg_busy_o = (state_q == ST_PENDING);
    assign cfg_err_o  = err_q;

    uart_frac_div #(
        .INT_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_rx_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .restart_i  (apply | rx_resync_i),
        .div_int_i  (rx_int_q),
        .div_frac_i (rx_frac_q),
        .pls_o      (pls_rx_o)
    );

    uart_frac_div #(
        .INT_W  (TX_W),
        .FRAC_W (FRAC_W)
    ) u_tx_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .restart_i  (apply),
        .div_int_i  (tx_int_q),
        .div_frac_i (tx_frac_q),
        .pls_o      (pls_tx_o)
    );

endmodule
